// File: rtl/vga_fetch_sched.sv
// VGA timing generator and single-port VRAM scheduler: 8-clock slot map, writes in seq 1-3, video reads in seq 5-7.
// Outputs registered and aligned with the hCount they describe; a held wrReq waits for the next seq 1 (wrAck after 3-10 clocks).
module vga_fetch_sched #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_X0    = 64,
    parameter int FB_Y0    = 69,
    parameter int FB_BYTES = 64,
    parameter int FB_LINES = 342
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        wrReq,
    input  logic [14:0] wrAddr,
    input  logic [7:0]  wrData,
    output logic        wrAck,
    output logic [14:0] ramAddr,
    output logic [7:0]  ramDqOut,
    output logic        ramDqOe,
    input  logic [7:0]  ramDqIn,
    output logic        nRamCE,
    output logic        nRamOE,
    output logic        nRamWE,
    output logic [7:0]  parOut,
    output logic [2:0]  seq,
    output logic        vidActive,
    output logic        nHSync,
    output logic        nVSync
);

    localparam int          H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG       = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END       = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG       = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END       = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  FB_Y_BEG     = 10'(FB_Y0);
    localparam logic [9:0]  FB_Y_END     = 10'(FB_Y0 + FB_LINES);
    localparam logic [6:0]  G_FIRST      = 7'(FB_X0 / 8 - 1);
    localparam logic [6:0]  G_LAST       = 7'(FB_X0 / 8 + FB_BYTES - 2);
    localparam logic [9:0]  H_LAST_FETCH = 10'((FB_X0 / 8 + FB_BYTES - 2) * 8 + 7);
    localparam logic [14:0] LINE_STEP    = 15'(FB_BYTES);

    typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_STROBE, WR_HOLD} wr_state_t;

    logic [9:0]  r_hcnt, r_vcnt;
    logic [14:0] r_line_base;
    wr_state_t   r_state;
    logic        r_vid, r_hs_n, r_vs_n, r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_ack;
    logic [14:0] r_addr;
    logic [7:0]  r_dq_out, r_par;

    logic [9:0]  w_h_nxt, w_v_nxt;
    logic [2:0]  w_seq_nxt;
    logic [6:0]  w_grp_nxt, w_grp_off;
    logic        w_fetch_nxt, w_rd_nxt, w_wr_busy;
    logic [14:0] w_rd_addr, w_addr_nxt;
    logic [7:0]  w_dq_out_nxt, w_par_nxt;
    wr_state_t   w_state_nxt;

    always_comb begin
        w_h_nxt = r_hcnt + 10'd1;
        w_v_nxt = r_vcnt;
        if (r_hcnt == H_LAST) begin
            w_h_nxt = '0;
            w_v_nxt = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end
    end

    // Everything below looks one clock ahead so registered outputs line up with the counter.
    assign w_seq_nxt   = w_h_nxt[2:0];
    assign w_grp_nxt   = w_h_nxt[9:3];
    assign w_fetch_nxt = (w_v_nxt >= FB_Y_BEG) && (w_v_nxt < FB_Y_END) &&
                         (w_grp_nxt >= G_FIRST) && (w_grp_nxt <= G_LAST);
    assign w_rd_nxt    = w_fetch_nxt && (w_seq_nxt >= 3'd5);
    assign w_grp_off   = w_grp_nxt - G_FIRST;
    assign w_rd_addr   = r_line_base + {8'd0, w_grp_off};

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_line_base <= '0;
        end else begin
            r_hcnt <= w_h_nxt;
            r_vcnt <= w_v_nxt;
            if (r_hcnt == H_LAST && r_vcnt == V_LAST)
                r_line_base <= '0;
            else if (r_hcnt == H_LAST_FETCH && r_vcnt >= FB_Y_BEG && r_vcnt < FB_Y_END)
                r_line_base <= r_line_base + LINE_STEP;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_state <= WR_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WR_IDLE:   if (w_seq_nxt == 3'd1 && wrReq) w_state_nxt = WR_SETUP;
            WR_SETUP:  w_state_nxt = WR_STROBE;
            WR_STROBE: w_state_nxt = WR_HOLD;
            WR_HOLD:   w_state_nxt = WR_IDLE;
            default:   w_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        w_wr_busy    = (w_state_nxt != WR_IDLE);
        w_addr_nxt   = r_addr;
        w_dq_out_nxt = r_dq_out;
        if (w_state_nxt == WR_SETUP) begin
            w_addr_nxt   = wrAddr;
            w_dq_out_nxt = wrData;
        end else if (w_rd_nxt) begin
            w_addr_nxt = w_rd_addr;
        end
        // Capture at the end of each read cycle; non-fetch groups shift out black.
        w_par_nxt = r_par;
        if (!r_oe_n)
            w_par_nxt = ramDqIn;
        else if (w_seq_nxt == 3'd5 && !w_fetch_nxt)
            w_par_nxt = 8'h00;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_vid    <= 1'b0;
            r_hs_n   <= 1'b1;
            r_vs_n   <= 1'b1;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_ack    <= 1'b0;
            r_addr   <= '0;
            r_dq_out <= '0;
            r_par    <= '0;
        end else begin
            r_vid    <= (w_v_nxt < V_ACT) && (w_h_nxt < H_ACT);
            r_hs_n   <= !((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END));
            r_vs_n   <= !((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END));
            r_ce_n   <= !(w_rd_nxt || w_wr_busy);
            r_oe_n   <= !w_rd_nxt;
            r_we_n   <= (w_state_nxt != WR_STROBE);
            r_dq_oe  <= w_wr_busy;
            r_ack    <= (w_state_nxt == WR_HOLD);
            r_addr   <= w_addr_nxt;
            r_dq_out <= w_dq_out_nxt;
            r_par    <= w_par_nxt;
        end
    end

    assign seq       = r_hcnt[2:0];
    assign vidActive = r_vid;
    assign nHSync    = r_hs_n;
    assign nVSync    = r_vs_n;
    assign nRamCE    = r_ce_n;
    assign nRamOE    = r_oe_n;
    assign nRamWE    = r_we_n;
    assign ramDqOe   = r_dq_oe;
    assign wrAck     = r_ack;
    assign ramAddr   = r_addr;
    assign ramDqOut  = r_dq_out;
    assign parOut    = r_par;

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Bench for vga_fetch_sched on a shrunken 120x48 raster (80x40 visible, 8x20 byte framebuffer at x=16, y=5).
// VRAM model: byte a initially holds a[7:0]; writes land when CE and WE are both low.
module tb_vga_fetch_sched;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        wrReq = 1'b0;
    logic [14:0] wrAddr = '0;
    logic [7:0]  wrData = '0;
    logic        wrAck;
    logic [14:0] ramAddr;
    logic [7:0]  ramDqOut;
    logic        ramDqOe;
    logic [7:0]  ramDqIn;
    logic        nRamCE, nRamOE, nRamWE;
    logic [7:0]  parOut;
    logic [2:0]  seq;
    logic        vidActive, nHSync, nVSync;

    vga_fetch_sched #(
        .H_ACTIVE(80), .H_FP(8), .H_SYNC(16), .H_BP(16),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .FB_X0(16), .FB_Y0(5), .FB_BYTES(8), .FB_LINES(20)
    ) dut (
        .clk(clk), .nReset(nReset), .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData),
        .wrAck(wrAck), .ramAddr(ramAddr), .ramDqOut(ramDqOut), .ramDqOe(ramDqOe),
        .ramDqIn(ramDqIn), .nRamCE(nRamCE), .nRamOE(nRamOE), .nRamWE(nRamWE),
        .parOut(parOut), .seq(seq), .vidActive(vidActive), .nHSync(nHSync), .nVSync(nVSync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference raster position, 120 clocks/line, 48 lines/frame.
    int tb_h = 0, tb_v = 0, tb_f = 0;
    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            tb_h <= 0; tb_v <= 0; tb_f <= 0;
        end else if (tb_h == 119) begin
            tb_h <= 0;
            if (tb_v == 47) begin tb_v <= 0; tb_f <= tb_f + 1; end
            else tb_v <= tb_v + 1;
        end else begin
            tb_h <= tb_h + 1;
        end
    end

    logic [7:0] mem [0:32767];
    bit mem_init = 0;
    assign ramDqIn = (!nRamCE && !nRamOE) ? mem[ramAddr] : 8'hEE;

    int ovl_cnt = 0, dqoe_bad = 0, vid_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32768; i++) mem[i] = 8'(i);
            mem_init = 1;
        end
        if (nReset) begin
            if (!nRamCE && !nRamWE) mem[ramAddr] = ramDqOut;
            if (!nRamOE && !nRamWE) ovl_cnt++;
            if (ramDqOe && seq >= 3'd4) dqoe_bad++;
            if (tb_f == 1) begin
                if (vidActive) vid_cnt++;
                if (!nHSync) hs_cnt++;
                if (!nVSync) vs_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int f; int v; int h;
        logic vid; logic hs_n; logic vs_n; logic oe_n;
        logic [7:0] par;
        logic chk_addr;
        logic [14:0] addr;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int f, v, h, input logic vid, hs_n, vs_n, oe_n,
                       input logic [7:0] par, input logic chk_addr, input int addr);
        vec_t t;
        t.f = f; t.v = v; t.h = h; t.vid = vid; t.hs_n = hs_n; t.vs_n = vs_n; t.oe_n = oe_n;
        t.par = par; t.chk_addr = chk_addr; t.addr = 15'(addr);
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_pos(input int f, v, h, output bit ok);
        ok = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (tb_f == f && tb_v == v && tb_h == h) begin ok = 1; return; end
        end
    endtask

    task automatic wait_seq(input int s);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (tb_h % 8 == s) return;
        end
        checks++; failures++;
        $display("FAIL wait_seq: seq %0d never reached", s);
    endtask

    // Returns clocks from request to the wrAck pulse, or -1 if no ack.
    task automatic do_write(input logic [14:0] a, input logic [7:0] d, input int start_seq,
                            input int drop_at, output int lat);
        bit seen = 0;
        wait_seq(start_seq);
        wrReq = 1'b1; wrAddr = a; wrData = d;
        lat = 0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            lat++;
            if (lat == drop_at) begin wrReq = 1'b0; wrData = ~d; end
            if (wrAck) seen = 1;
        end
        wrReq = 1'b0;
        if (!seen) lat = -1;
    endtask

    vec_t vv;
    bit   ok;
    int   lat, acks, last, bad_gap, oe_lo;

    initial begin
        //   f  v   h   vid hs vs oe  par    ca addr
        add(0, 0,   1,  1, 1, 1, 1, 8'h00, 0, 0);
        add(0, 0,  79,  1, 1, 1, 1, 8'h00, 0, 0);
        add(0, 0,  80,  0, 1, 1, 1, 8'h00, 0, 0);
        add(0, 0,  87,  0, 1, 1, 1, 8'h00, 0, 0);
        add(0, 0,  88,  0, 0, 1, 1, 8'h00, 0, 0);
        add(0, 0, 103,  0, 0, 1, 1, 8'h00, 0, 0);
        add(0, 0, 104,  0, 1, 1, 1, 8'h00, 0, 0);
        add(0, 5,  13,  1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 5,  15,  1, 1, 1, 0, 8'h00, 1, 0);
        add(0, 5,  23,  1, 1, 1, 0, 8'h01, 1, 1);
        add(0, 5,  71,  1, 1, 1, 0, 8'h07, 1, 7);
        add(0, 5,  77,  1, 1, 1, 1, 8'h00, 0, 0);
        add(0, 6,  13,  1, 1, 1, 0, 8'h00, 1, 8);
        add(0, 6,  15,  1, 1, 1, 0, 8'h08, 1, 8);
        add(0, 24, 71,  1, 1, 1, 0, 8'h9F, 1, 159);
        add(0, 25, 13,  1, 1, 1, 1, 8'h00, 0, 0);
        add(0, 39, 79,  1, 1, 1, 1, 8'h00, 0, 0);
        add(0, 40,  0,  0, 1, 1, 1, 8'h00, 0, 0);
        add(0, 41, 119, 0, 1, 1, 1, 8'h00, 0, 0);
        add(0, 42,  0,  0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 43, 119, 0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 44,  0,  0, 1, 1, 1, 8'h00, 0, 0);
        add(1, 0,   0,  1, 1, 1, 1, 8'h00, 0, 0);
        add(1, 5,  13,  1, 1, 1, 0, 8'h00, 1, 0);
        add(1, 5,  15,  1, 1, 1, 0, 8'h00, 1, 0);

        repeat (3) @(negedge clk);
        chk("reset_state",
            32'({seq, vidActive, nHSync, nVSync, nRamCE, nRamOE, nRamWE, ramDqOe, wrAck}),
            32'({3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
        chk("reset_buses", 32'({ramAddr, ramDqOut, parOut}), 32'(0));
        nReset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vv = vecs[i];
            wait_pos(vv.f, vv.v, vv.h, ok);
            if (!ok) begin
                checks++; failures++;
                $display("FAIL vec%0d: position f%0d v%0d h%0d never reached", i, vv.f, vv.v, vv.h);
            end else begin
                chk($sformatf("vec%0d_f%0d_v%0d_h%0d", i, vv.f, vv.v, vv.h),
                    32'({vidActive, nHSync, nVSync, nRamOE, seq, parOut}),
                    32'({vv.vid, vv.hs_n, vv.vs_n, vv.oe_n, 3'(vv.h % 8), vv.par}));
                if (vv.chk_addr)
                    chk($sformatf("vec%0d_addr", i), 32'(ramAddr), 32'(vv.addr));
            end
        end

        // Request at seq 3: SETUP on the following seq 1, WE low only at seq 2, ack at seq 3.
        wait_seq(3);
        wrReq = 1'b1; wrAddr = 15'h1234; wrData = 8'hA5;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            case (i)
                5: chk("wr_seq0", 32'({nRamCE, nRamWE, ramDqOe, wrAck}), 32'(4'b1100));
                6: begin
                    chk("wr_seq1", 32'({nRamCE, nRamOE, nRamWE, ramDqOe, wrAck}), 32'(5'b01110));
                    chk("wr_seq1_bus", 32'({ramAddr, ramDqOut}), 32'({15'h1234, 8'hA5}));
                end
                7: chk("wr_seq2", 32'({nRamCE, nRamOE, nRamWE, ramDqOe, wrAck}), 32'(5'b01010));
                8: begin
                    chk("wr_seq3", 32'({nRamCE, nRamOE, nRamWE, ramDqOe, wrAck}), 32'(5'b01111));
                    wrReq = 1'b0;
                end
                9: chk("wr_seq4", 32'({nRamCE, nRamOE, nRamWE, ramDqOe, wrAck}), 32'(5'b11100));
                default: ;
            endcase
        end
        chk("wr_mem_1234", 32'(mem[15'h1234]), 32'(8'hA5));

        do_write(15'h0100, 8'h5A, 0, -1, lat);
        chk("lat_min_seq0", 32'(lat), 32'(3));
        chk("mem_0100", 32'(mem[15'h0100]), 32'(8'h5A));
        do_write(15'h7FFF, 8'hC3, 1, -1, lat);
        chk("lat_max_seq1", 32'(lat), 32'(10));
        chk("mem_7fff", 32'(mem[15'h7FFF]), 32'(8'hC3));
        do_write(15'h0300, 8'h66, 0, 1, lat);
        chk("lat_dropped_req", 32'(lat), 32'(3));
        chk("mem_0300_dropped", 32'(mem[15'h0300]), 32'(8'h66));

        // Continuous request for one frame's worth of clocks.
        wait_seq(0);
        wrReq = 1'b1; wrAddr = 15'h4000; wrData = 8'h11;
        acks = 0; last = -1; bad_gap = 0; oe_lo = 0;
        for (int i = 1; i <= 5760; i++) begin
            @(negedge clk);
            if (!nRamOE) oe_lo++;
            if (wrAck) begin
                acks++;
                if (last >= 0 && i - last != 8) bad_gap++;
                last = i;
            end
        end
        wrReq = 1'b0;
        chk("stress_acks", 32'(acks), 32'(720));
        chk("stress_ack_spacing", 32'(bad_gap), 32'(0));
        chk("stress_video_reads", 32'(oe_lo), 32'(480));

        chk("frame1_vid_clocks", 32'(vid_cnt), 32'(3200));
        chk("frame1_hsync_clocks", 32'(hs_cnt), 32'(768));
        chk("frame1_vsync_clocks", 32'(vs_cnt), 32'(240));

        // Reset pulse while WE is asserted.
        wait_seq(0);
        wrReq = 1'b1; wrAddr = 15'h0200; wrData = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("strobe_before_reset", 32'({nRamWE, ramDqOe}), 32'(2'b01));
        #2 nReset = 1'b0;
        #1;
        chk("async_reset_strobes",
            32'({nRamCE, nRamOE, nRamWE, ramDqOe, wrAck, seq, vidActive}),
            32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}));
        wrReq = 1'b0;
        @(negedge clk);
        chk("reset_held_seq", 32'({seq, wrAck, nHSync, nVSync}), 32'({3'd0, 1'b0, 1'b1, 1'b1}));
        nReset = 1'b1;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (wrAck) acks++;
        end
        chk("no_ack_after_reset", 32'(acks), 32'(0));
        chk("counter_restart_seq", 32'(seq), 32'(3'(tb_h % 8)));
        do_write(15'h0200, 8'h77, 0, -1, lat);
        chk("rerequest_lat", 32'(lat), 32'(3));
        chk("rerequest_mem", 32'(mem[15'h0200]), 32'(8'h77));

        chk("oe_we_overlap", 32'(ovl_cnt), 32'(0));
        chk("dqoe_in_seq4_7", 32'(dqoe_bad), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
